sent_rx_fast_unpack: RTL and testbench

Parametrised fast-channel unpacker for the SENT receiver. It sits between the store FIFO of decoded fast-channel frames and the RX output FIFO. Once the slow-channel message has been decoded, the block reads one stored frame per step and splits its nibbles according to the fast-channel format ID. It tags each result with its channel number and CRC status, then writes one or two words per frame to the RX FIFO. Unlike its predecessor it runs on a single clock edge, back-pressures on a full output FIFO, queues CRC results in a real FIFO, and flags unknown formats and secure-sensor check failures.

---
 rtl/sent_rx_fast_unpack.sv | 185 ++++++++++++++++++
 tb/tb_sent_rx_fast_unpack.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sent_rx_fast_unpack.sv
// SENT fast-channel unpacker: pulls decoded frames from the store FIFO, splits the
// nibbles by fast-channel format and writes tagged ch1/ch2 words to the RX FIFO.
module sent_rx_fast_unpack #(
  parameter int NIBBLES      = 6,
  parameter int OUT_W        = 16,
  parameter int FRAMES_SHORT = 16,
  parameter int FRAMES_LONG  = 18,
  parameter int FLAG_DEPTH   = 32,
  parameter int DROP_BAD     = 0
) (
  input  logic                 clk_rx,
  input  logic                 reset_rx,
  input  logic                 start,
  input  logic                 channel_format,
  input  logic [15:0]          format_id,
  input  logic                 crc_done,
  input  logic                 crc_ok,
  input  logic                 store_empty,
  output logic                 store_rd_en,
  input  logic [NIBBLES*4-1:0] store_data,
  input  logic                 fifo_full,
  output logic                 wr_en,
  output logic [OUT_W-1:0]     wr_data,
  output logic                 wr_chan,
  output logic                 wr_err,
  output logic                 busy,
  output logic                 done,
  output logic                 fmt_err,
  output logic                 flag_ovf
);
  localparam int SW = NIBBLES * 4;
  localparam int AW = $clog2(FLAG_DEPTH);
  localparam int CW = $clog2(FRAMES_LONG + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_CH1, S_CH2, S_NEXT, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      fmt_q;
  logic            long_q;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   frame_target;
  logic            flag_p1;
  logic [SW-1:0]   frame_p1;
  logic [OUT_W-1:0] data_hold;
  logic            chan_hold, err_hold;
  logic            wr, flag_pop;
  logic            write_ok, has_ch2, last_frame, sec_fail;
  logic [OUT_W-1:0] cur_data;
  logic            cur_chan, cur_err;

  logic            flag_mem [FLAG_DEPTH];
  logic [AW-1:0]   flag_wr_ptr, flag_rd_ptr;
  logic [AW:0]     flag_cnt;
  logic            flag_pop_eff, flag_push_eff, flag_head;

  // 0 marks an unsupported format; 1..7 are carried through as-is
  function automatic logic [2:0] fmt_code(input logic [15:0] id);
    if (id >= 16'd1 && id <= 16'd7) return id[2:0];
    return 3'd0;
  endfunction

  function automatic logic [OUT_W-1:0] unpack_ch1(input logic [2:0] f, input logic [SW-1:0] d);
    case (f)
      3'd6:    return OUT_W'({d[23:12], d[11:10]});
      3'd7:    return OUT_W'(d[23:8]);
      default: return OUT_W'(d[23:12]);
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] unpack_ch2(input logic [2:0] f, input logic [SW-1:0] d);
    case (f)
      3'd1:    return OUT_W'({d[3:0], d[7:4], d[11:8]});
      3'd4:    return OUT_W'(d[11:4]);
      3'd6:    return OUT_W'({d[9:8], d[3:0], d[7:4]});
      3'd7:    return OUT_W'({d[3:0], d[7:4]});
      default: return '0;
    endcase
  endfunction

  // CRC flag FIFO; a pop on empty reads 0, a push on full is dropped and flagged
  assign flag_pop_eff  = flag_pop && (flag_cnt != '0);
  assign flag_push_eff = crc_done && ((flag_cnt != (AW+1)'(FLAG_DEPTH)) || flag_pop_eff);
  assign flag_head     = flag_pop_eff ? flag_mem[flag_rd_ptr] : 1'b0;

  always_ff @(posedge clk_rx) begin
    if (flag_push_eff) flag_mem[flag_wr_ptr] <= crc_ok;
  end

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      flag_wr_ptr <= '0;
      flag_rd_ptr <= '0;
      flag_cnt    <= '0;
      flag_ovf    <= 1'b0;
    end else begin
      if (flag_push_eff) flag_wr_ptr <= flag_wr_ptr + AW'(1);
      if (flag_pop_eff)  flag_rd_ptr <= flag_rd_ptr + AW'(1);
      case ({flag_push_eff, flag_pop_eff})
        2'b10:   flag_cnt <= flag_cnt + (AW+1)'(1);
        2'b01:   flag_cnt <= flag_cnt - (AW+1)'(1);
        default: flag_cnt <= flag_cnt;
      endcase
      if (crc_done && !flag_push_eff) flag_ovf <= 1'b1;
    end
  end

  assign frame_target = long_q ? CW'(FRAMES_LONG) : CW'(FRAMES_SHORT);
  assign last_frame   = (frame_cnt + CW'(1)) == frame_target;
  assign write_ok     = (fmt_q != 3'd0) && ((DROP_BAD == 0) || flag_p1);
  assign has_ch2      = (fmt_q == 3'd1) || (fmt_q == 3'd4) || (fmt_q == 3'd6) || (fmt_q == 3'd7);
  assign sec_fail     = (fmt_q == 3'd4) && (frame_p1[3:0] != ~frame_p1[23:20]);

  always_comb begin
    state_nxt = state;
    flag_pop  = 1'b0;
    wr        = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (!store_empty) begin
        flag_pop  = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = write_ok ? S_CH1 : S_NEXT;
      S_CH1:   if (!fifo_full) begin
        wr        = 1'b1;
        state_nxt = has_ch2 ? S_CH2 : S_NEXT;
      end
      S_CH2:   if (!fifo_full) begin
        wr        = 1'b1;
        state_nxt = S_NEXT;
      end
      S_NEXT:  state_nxt = last_frame ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // p1: frame word registered in LATCH, unpacked while in CH1/CH2
  always_ff @(posedge clk_rx) begin
    if (state == S_LATCH) frame_p1 <= store_data;
  end

  assign cur_chan = (state == S_CH2);
  assign cur_data = cur_chan ? unpack_ch2(fmt_q, frame_p1) : unpack_ch1(fmt_q, frame_p1);
  assign cur_err  = !flag_p1 || sec_fail;

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      state     <= S_IDLE;
      fmt_q     <= 3'd0;
      long_q    <= 1'b0;
      frame_cnt <= '0;
      flag_p1   <= 1'b0;
      fmt_err   <= 1'b0;
      data_hold <= '0;
      chan_hold <= 1'b0;
      err_hold  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        fmt_q     <= fmt_code(format_id);
        long_q    <= channel_format;
        frame_cnt <= '0;
        fmt_err   <= (fmt_code(format_id) == 3'd0);
      end
      if (flag_pop) flag_p1 <= flag_head;
      if (state == S_NEXT) frame_cnt <= frame_cnt + CW'(1);
      if (wr) begin
        data_hold <= cur_data;
        chan_hold <= cur_chan;
        err_hold  <= cur_err;
      end
    end
  end

  assign store_rd_en = flag_pop;
  assign wr_en       = wr;
  assign wr_data     = wr ? cur_data : data_hold;
  assign wr_chan     = wr ? cur_chan : chan_hold;
  assign wr_err      = wr ? cur_err  : err_hold;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
endmodule

// File: tb/tb_sent_rx_fast_unpack.sv
// Bench for sent_rx_fast_unpack: two instances (DROP_BAD=0 and 1) share stimulus;
// a per-instance queue of expected writes is filled before each message starts.
module tb_sent_rx_fast_unpack;
  logic        clk_rx = 1'b0;
  logic        reset_rx = 1'b1;
  logic        start = 1'b0, channel_format = 1'b0;
  logic [15:0] format_id = '0;
  logic        crc_done = 1'b0, crc_ok = 1'b0;
  logic        store_empty = 1'b0, fifo_full = 1'b0;
  logic [23:0] store_data = '0;

  logic        rd0, wr_en0, wr_chan0, wr_err0, busy0, done0, fmt_err0, flag_ovf0;
  logic        rd1, wr_en1, wr_chan1, wr_err1, busy1, done1, fmt_err1, flag_ovf1;
  logic [15:0] wr_data0, wr_data1;

  int checks = 0, errors = 0;
  int wr_cnt0, rd_cnt0, rd_cnt1, done_cnt0, done_cnt1;
  logic [17:0] q0[$];
  logic [17:0] q1[$];

  always #5 clk_rx = ~clk_rx;

  sent_rx_fast_unpack #(.DROP_BAD(0)) u0 (
    .clk_rx(clk_rx), .reset_rx(reset_rx), .start(start), .channel_format(channel_format),
    .format_id(format_id), .crc_done(crc_done), .crc_ok(crc_ok), .store_empty(store_empty),
    .store_rd_en(rd0), .store_data(store_data), .fifo_full(fifo_full), .wr_en(wr_en0),
    .wr_data(wr_data0), .wr_chan(wr_chan0), .wr_err(wr_err0), .busy(busy0), .done(done0),
    .fmt_err(fmt_err0), .flag_ovf(flag_ovf0));

  sent_rx_fast_unpack #(.DROP_BAD(1)) u1 (
    .clk_rx(clk_rx), .reset_rx(reset_rx), .start(start), .channel_format(channel_format),
    .format_id(format_id), .crc_done(crc_done), .crc_ok(crc_ok), .store_empty(store_empty),
    .store_rd_en(rd1), .store_data(store_data), .fifo_full(fifo_full), .wr_en(wr_en1),
    .wr_data(wr_data1), .wr_chan(wr_chan1), .wr_err(wr_err1), .busy(busy1), .done(done1),
    .fmt_err(fmt_err1), .flag_ovf(flag_ovf1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input int id, input logic [17:0] obs);
    logic [17:0] exp;
    int sz;
    sz = (id == 0) ? q0.size() : q1.size();
    checks++;
    assert (sz > 0) else begin
      errors++;
      $error("FAIL wr%0d_extra got %h exp none", id, obs);
    end
    if (sz > 0) begin
      if (id == 0) exp = q0.pop_front();
      else         exp = q1.pop_front();
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL wr%0d_word got %h exp %h", id, obs, exp);
      end
    end
  endtask

  always @(negedge clk_rx) begin
    if (!reset_rx) begin
      if (wr_en0) begin
        wr_cnt0++;
        chk_wr(0, {wr_data0, wr_chan0, wr_err0});
      end
      if (wr_en1) chk_wr(1, {wr_data1, wr_chan1, wr_err1});
      if (rd0) rd_cnt0++;
      if (rd1) rd_cnt1++;
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
      if (fifo_full)   chk("full_stall_wr", {wr_en0, wr_en1}, 0);
      if (store_empty) chk("empty_stall_rd", {rd0, rd1}, 0);
    end
  end

  task automatic step();
    @(posedge clk_rx);
    #1;
  endtask

  // Reference split of one frame into the writes it should produce
  task automatic exp_frame(input logic [15:0] fid, input logic [23:0] d, input logic flag);
    logic [3:0] n0, n1, n2, n3, n4, n5;
    logic [15:0] c1, c2;
    logic sec;
    int nw;
    n0 = d[23:20]; n1 = d[19:16]; n2 = d[15:12];
    n3 = d[11:8];  n4 = d[7:4];   n5 = d[3:0];
    c1 = {4'h0, n0, n1, n2};
    c2 = '0;
    sec = 1'b0;
    nw = 0;
    case (fid)
      16'd1: begin c2 = {4'h0, n5, n4, n3}; nw = 2; end
      16'd2, 16'd3, 16'd5: nw = 1;
      16'd4: begin c2 = {8'h00, n3, n4}; sec = (n5 != ~n0); nw = 2; end
      16'd6: begin c1 = {2'b00, n0, n1, n2, n3[3:2]}; c2 = {6'b0, n3[1:0], n5, n4}; nw = 2; end
      16'd7: begin c1 = {n0, n1, n2, n3}; c2 = {8'h00, n5, n4}; nw = 2; end
      default: nw = 0;
    endcase
    if (nw >= 1) begin
      q0.push_back({c1, 1'b0, !flag || sec});
      if (flag) q1.push_back({c1, 1'b0, sec});
    end
    if (nw == 2) begin
      q0.push_back({c2, 1'b1, !flag || sec});
      if (flag) q1.push_back({c2, 1'b1, sec});
    end
  endtask

  task automatic push_flags(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      crc_done = 1'b1;
      crc_ok   = (mode == 1) ? (i % 2 == 0) : 1'b1;
      step();
    end
    crc_done = 1'b0;
    crc_ok   = 1'b0;
  endtask

  // fmode: 0 all flags good, 1 alternating good/bad, 2 no flags pushed
  task automatic run_msg(input string tag, input logic [15:0] fid, input logic cf,
                         input logic [23:0] d, input int fmode, input bit stall);
    int nfr, cyc;
    bit did_full, did_empty;
    nfr = cf ? 18 : 16;
    cyc = 0;
    did_full = 0;
    did_empty = 0;
    store_data = d;
    store_empty = 1'b0;
    if (fmode != 2) push_flags(nfr, fmode);
    for (int i = 0; i < nfr; i++)
      exp_frame(fid, d, (fmode == 0) ? 1'b1 : (fmode == 1) ? (i % 2 == 0) : 1'b0);
    wr_cnt0 = 0; rd_cnt0 = 0; rd_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    start = 1'b1; channel_format = cf; format_id = fid;
    step();
    start = 1'b0; channel_format = 1'b0; format_id = 16'hFFFF;
    while ((done_cnt0 == 0 || done_cnt1 == 0) && cyc < 600) begin
      if (stall && !did_full && wr_cnt0 == 5) begin
        did_full = 1;
        fifo_full = 1'b1;
        repeat (10) step();
        fifo_full = 1'b0;
      end else if (stall && !did_empty && wr_cnt0 == 10) begin
        did_empty = 1;
        store_empty = 1'b1;
        repeat (5) step();
        store_empty = 1'b0;
      end else begin
        step();
        cyc++;
      end
    end
    repeat (3) step();
    chk({tag, "_done0"}, done_cnt0, 1);
    chk({tag, "_done1"}, done_cnt1, 1);
    chk({tag, "_reads0"}, rd_cnt0, nfr);
    chk({tag, "_reads1"}, rd_cnt1, nfr);
    chk({tag, "_left0"}, q0.size(), 0);
    chk({tag, "_left1"}, q1.size(), 0);
    chk({tag, "_busy"}, {busy0, busy1}, 0);
    chk({tag, "_fmt_err"}, {fmt_err0, fmt_err1}, (fid >= 1 && fid <= 7) ? 2'b00 : 2'b11);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int cyc;
    repeat (2) step();
    chk("rst_out0", {busy0, wr_en0, rd0, done0, wr_data0, wr_chan0, wr_err0, fmt_err0, flag_ovf0}, 0);
    chk("rst_out1", {busy1, wr_en1, rd1, done1, wr_data1, wr_chan1, wr_err1, fmt_err1, flag_ovf1}, 0);
    reset_rx = 1'b0;
    step();
    chk("idle_after_rst", {busy0, busy1, rd0, rd1}, 0);

    run_msg("fmt1", 16'd1, 1'b0, 24'hABC123, 0, 0);
    run_msg("fmt6", 16'd6, 1'b1, 24'h123456, 0, 0);
    run_msg("fmt4_ok", 16'd4, 1'b0, 24'h5A36BA, 0, 0);
    run_msg("fmt4_bad", 16'd4, 1'b0, 24'h5A36B0, 0, 0);
    run_msg("fmt2_alt", 16'd2, 1'b0, 24'hABC123, 1, 0);
    run_msg("fmt1_stall", 16'd1, 1'b0, 24'h9E4C71, 0, 1);
    run_msg("fmt7_noflag", 16'd7, 1'b0, 24'hFEDCBA, 2, 0);
    run_msg("fmt9", 16'h0009, 1'b0, 24'h111111, 0, 0);
    run_msg("fmt5", 16'd5, 1'b1, 24'h0F0F0F, 0, 0);

    push_flags(33, 0);
    chk("flag_ovf", {flag_ovf0, flag_ovf1}, 2'b11);

    store_data = 24'hABC123;
    exp_frame(16'd1, 24'hABC123, 1'b1);
    wr_cnt0 = 0;
    start = 1'b1; channel_format = 1'b0; format_id = 16'd1;
    step();
    start = 1'b0;
    cyc = 0;
    while (wr_cnt0 == 0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("mid_msg_wr_seen", wr_cnt0, 1);
    chk("mid_msg_active", {busy0, wr_en0}, 2'b11);
    reset_rx = 1'b1;
    #1;
    chk("abort_out0", {busy0, wr_en0, rd0, done0, wr_data0, wr_chan0, wr_err0, fmt_err0, flag_ovf0}, 0);
    chk("abort_out1", {busy1, wr_en1, rd1, done1, wr_data1, wr_chan1, wr_err1, fmt_err1, flag_ovf1}, 0);
    q0.delete();
    q1.delete();
    step();
    reset_rx = 1'b0;
    rd_cnt0 = 0;
    repeat (20) step();
    chk("abort_stays_idle", {busy0, busy1}, 0);
    chk("abort_no_reads", rd_cnt0, 0);
    chk("abort_no_writes", wr_cnt0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
